// File: rtl/ep_pkg.sv
// ep_pkg: shared types and helpers for the episodic tracker.
//   - ep_state_e : tracker state (EP_IDLE = no episode, EP_TRACK = episode held)
//   - STR_W / STR_MAX : episode strength width and ceiling
//   - sat_add / sat_sub : strength arithmetic clamped to [0, STR_MAX]
package ep_pkg;

  typedef enum logic {
    EP_IDLE  = 1'b0,
    EP_TRACK = 1'b1
  } ep_state_e;

  localparam int unsigned   STR_W   = 4;
  localparam logic [STR_W-1:0] STR_MAX = 4'd15;

  // The sum is formed one bit wider so a carry out is seen as overflow.
  function automatic logic [STR_W-1:0] sat_add(input logic [STR_W-1:0] a,
                                               input logic [STR_W-1:0] b);
    logic [STR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, STR_MAX}) return STR_MAX;
    else                     return s[STR_W-1:0];
  endfunction

  function automatic logic [STR_W-1:0] sat_sub(input logic [STR_W-1:0] a,
                                               input logic [STR_W-1:0] b);
    if (a > b) return a - b;
    else       return '0;
  endfunction

endpackage

// File: rtl/ep_vote.sv
// ep_vote: combinational argmax over the per-pattern vote counters.
//   cnt    : packed array of N_PAT counters, CNT_W bits each
//   dom_id : index of the largest counter; ties resolve to the lowest index
module ep_vote #(
  parameter int N_PAT = 4,
  parameter int CNT_W = 4,
  parameter int ID_W  = $clog2(N_PAT)
) (
  input  logic [N_PAT-1:0][CNT_W-1:0] cnt,
  output logic [ID_W-1:0]             dom_id
);

  logic [CNT_W-1:0] best;

  // Strict greater-than keeps the earlier (lower) index on ties.
  always_comb begin
    best   = cnt[0];
    dom_id = '0;
    for (int unsigned i = 1; i < N_PAT; i++) begin
      if (cnt[i] > best) begin
        best   = cnt[i];
        dom_id = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/episodic_tracker.sv
// episodic_tracker: per-theta-window episode strength tracker.
// Counts gamma-cycle winners per pattern within each theta window, elects the
// dominant pattern at theta_tick and reinforces, weakens, replaces or drops the
// stored episode.
//   clk, rst_n   : clock, asynchronous active-low reset
//   theta_tick   : closes the current window (one-cycle pulse)
//   spike_valid  : a winner is present this cycle, index on spike_id
//   ep_strength  : episode strength 0..15
//   ep_valid     : an episode is held
//   ep_id        : stored episode pattern
//   ep_update    : one-cycle pulse after every window evaluation
// Optional feature macro: EP_DECAY_EN -- each non-qualifying window in TRACK
// also lowers strength by 1, dropping to IDLE when it reaches 0.
module episodic_tracker
  import ep_pkg::*;
#(
  parameter int               N_PAT       = 4,
  parameter int               ID_W        = $clog2(N_PAT),
  parameter int               CNT_W       = 4,
  parameter int               MIN_SPIKES  = 2,
  parameter logic [STR_W-1:0] INIT_STR    = 4'd4,
  parameter logic [STR_W-1:0] INC_STR     = 4'd2,
  parameter logic [STR_W-1:0] DEC_STR     = 4'd2,
  parameter int               EMPTY_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             theta_tick,
  input  logic             spike_valid,
  input  logic [ID_W-1:0]  spike_id,
  output logic [STR_W-1:0] ep_strength,
  output logic             ep_valid,
  output logic [ID_W-1:0]  ep_id,
  output logic             ep_update
);

  localparam int EMP_W = $clog2(EMPTY_LIMIT + 1);

  ep_state_e                   state_q, state_d;
  logic [N_PAT-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]            total_q, total_d;
  logic [EMP_W-1:0]            empty_q, empty_d;
  logic [STR_W-1:0]            ep_strength_q, ep_strength_d;
  logic                        ep_valid_q, ep_valid_d;
  logic [ID_W-1:0]             ep_id_q, ep_id_d;
  logic                        ep_update_q, ep_update_d;

  logic [ID_W-1:0]  dom_id;
  logic             qualify;
  logic [STR_W-1:0] str_sub;
  logic [EMP_W-1:0] empty_nxt;

  ep_vote #(
    .N_PAT (N_PAT),
    .CNT_W (CNT_W),
    .ID_W  (ID_W)
  ) u_vote (
    .cnt    (cnt_q),
    .dom_id (dom_id)
  );

  assign qualify   = (total_q >= CNT_W'(MIN_SPIKES));
  assign empty_nxt = empty_q + 1'b1;

  // Vote counters: a spike coincident with the tick opens the new window.
  always_comb begin
    cnt_d   = cnt_q;
    total_d = total_q;
    if (theta_tick) begin
      cnt_d   = '0;
      total_d = '0;
      if (spike_valid) begin
        cnt_d[spike_id] = CNT_W'(1);
        total_d         = CNT_W'(1);
      end
    end else if (spike_valid) begin
      if (cnt_q[spike_id] != '1) cnt_d[spike_id] = cnt_q[spike_id] + 1'b1;
      if (total_q != '1)         total_d = total_q + 1'b1;
    end
  end

  // Episode FSM, evaluated only on theta_tick.
  always_comb begin
    state_d       = state_q;
    empty_d       = empty_q;
    ep_strength_d = ep_strength_q;
    ep_valid_d    = ep_valid_q;
    ep_id_d       = ep_id_q;
    ep_update_d   = 1'b0;
    str_sub       = '0;

    if (theta_tick) begin
      ep_update_d = 1'b1;
      unique case (state_q)
        EP_IDLE: begin
          if (qualify) begin
            state_d       = EP_TRACK;
            ep_id_d       = dom_id;
            ep_strength_d = INIT_STR;
            ep_valid_d    = 1'b1;
            empty_d       = '0;
          end
        end
        EP_TRACK: begin
          if (qualify) begin
            empty_d = '0;
            if (dom_id == ep_id_q) begin
              ep_strength_d = sat_add(ep_strength_q, INC_STR);
            end else begin
              str_sub = sat_sub(ep_strength_q, DEC_STR);
              if (str_sub == '0) begin
                ep_id_d       = dom_id;
                ep_strength_d = INIT_STR;
              end else begin
                ep_strength_d = str_sub;
              end
            end
          end else begin
`ifdef EP_DECAY_EN
            str_sub = sat_sub(ep_strength_q, STR_W'(1));
            if ((str_sub == '0) || (int'(empty_nxt) >= EMPTY_LIMIT)) begin
              state_d       = EP_IDLE;
              empty_d       = '0;
              ep_strength_d = '0;
              ep_valid_d    = 1'b0;
              ep_id_d       = '0;
            end else begin
              empty_d       = empty_nxt;
              ep_strength_d = str_sub;
            end
`else
            if (int'(empty_nxt) >= EMPTY_LIMIT) begin
              state_d       = EP_IDLE;
              empty_d       = '0;
              ep_strength_d = '0;
              ep_valid_d    = 1'b0;
              ep_id_d       = '0;
            end else begin
              empty_d = empty_nxt;
            end
`endif
          end
        end
        default: state_d = EP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= EP_IDLE;
      cnt_q         <= '0;
      total_q       <= '0;
      empty_q       <= '0;
      ep_strength_q <= '0;
      ep_valid_q    <= 1'b0;
      ep_id_q       <= '0;
      ep_update_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      total_q       <= total_d;
      empty_q       <= empty_d;
      ep_strength_q <= ep_strength_d;
      ep_valid_q    <= ep_valid_d;
      ep_id_q       <= ep_id_d;
      ep_update_q   <= ep_update_d;
    end
  end

  assign ep_strength = ep_strength_q;
  assign ep_valid    = ep_valid_q;
  assign ep_id       = ep_id_q;
  assign ep_update   = ep_update_q;

endmodule

// File: tb/tb_episodic_tracker.sv
// Directed testbench for episodic_tracker. Inputs change #1 after the rising
// edge and outputs are sampled at the same point, well away from the edge.
module tb_episodic_tracker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       theta_tick = 1'b0;
  logic       spike_valid = 1'b0;
  logic [1:0] spike_id = '0;
  logic [3:0] ep_strength;
  logic       ep_valid;
  logic [1:0] ep_id;
  logic       ep_update;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  episodic_tracker #(
    .N_PAT       (4),
    .CNT_W       (4),
    .MIN_SPIKES  (2),
    .INIT_STR    (4'd4),
    .INC_STR     (4'd2),
    .DEC_STR     (4'd2),
    .EMPTY_LIMIT (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .theta_tick  (theta_tick),
    .spike_valid (spike_valid),
    .spike_id    (spike_id),
    .ep_strength (ep_strength),
    .ep_valid    (ep_valid),
    .ep_id       (ep_id),
    .ep_update   (ep_update)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic spike(input logic [1:0] id);
    spike_valid = 1'b1;
    spike_id    = id;
    step();
    spike_valid = 1'b0;
  endtask

  task automatic tick();
    theta_tick = 1'b1;
    step();
    theta_tick = 1'b0;
  endtask

  task automatic window(input logic [1:0] id, input int n);
    for (int k = 0; k < n; k++) spike(id);
    tick();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({ep_valid, ep_id, ep_strength, ep_update} !== 8'b0) begin
      errors++;
      $display("FAIL reset: got v=%0b id=%0d str=%0d upd=%0b exp all 0",
               ep_valid, ep_id, ep_strength, ep_update);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_create();
    apply_reset();
    window(2'd2, 3);
    checks++;
    if ({ep_valid, ep_id, ep_strength, ep_update} !== {1'b1, 2'd2, 4'd4, 1'b1}) begin
      errors++;
      $display("FAIL create: got v=%0b id=%0d str=%0d upd=%0b exp v=1 id=2 str=4 upd=1",
               ep_valid, ep_id, ep_strength, ep_update);
    end
    step();
    checks++;
    if ({ep_valid, ep_id, ep_strength, ep_update} !== {1'b1, 2'd2, 4'd4, 1'b0}) begin
      errors++;
      $display("FAIL create_hold: got v=%0b id=%0d str=%0d upd=%0b exp v=1 id=2 str=4 upd=0",
               ep_valid, ep_id, ep_strength, ep_update);
    end
  endtask

  task automatic test_reinforce();
    logic [3:0] exp_str [7];
    exp_str = '{4'd6, 4'd8, 4'd10, 4'd12, 4'd14, 4'd15, 4'd15};
    for (int w = 0; w < 7; w++) begin
      window(2'd2, 2);
      checks++;
      if ({ep_valid, ep_id, ep_strength, ep_update} !== {1'b1, 2'd2, exp_str[w], 1'b1}) begin
        errors++;
        $display("FAIL reinforce_%0d: got v=%0b id=%0d str=%0d upd=%0b exp v=1 id=2 str=%0d upd=1",
                 w, ep_valid, ep_id, ep_strength, ep_update, exp_str[w]);
      end
    end
  endtask

  task automatic test_replace();
    apply_reset();
    window(2'd2, 2);
    window(2'd1, 2);
    checks++;
    if ({ep_valid, ep_id, ep_strength} !== {1'b1, 2'd2, 4'd2}) begin
      errors++;
      $display("FAIL weaken: got v=%0b id=%0d str=%0d exp v=1 id=2 str=2",
               ep_valid, ep_id, ep_strength);
    end
    window(2'd1, 3);
    checks++;
    if ({ep_valid, ep_id, ep_strength} !== {1'b1, 2'd1, 4'd4}) begin
      errors++;
      $display("FAIL replace: got v=%0b id=%0d str=%0d exp v=1 id=1 str=4",
               ep_valid, ep_id, ep_strength);
    end
  endtask

  task automatic test_tie_and_low();
    apply_reset();
    window(2'd1, 1);
    checks++;
    if ({ep_valid, ep_id, ep_strength, ep_update} !== {1'b0, 2'd0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL idle_low: got v=%0b id=%0d str=%0d upd=%0b exp v=0 id=0 str=0 upd=1",
               ep_valid, ep_id, ep_strength, ep_update);
    end
    spike(2'd3); spike(2'd3); spike(2'd0); spike(2'd0);
    tick();
    checks++;
    if ({ep_valid, ep_id, ep_strength} !== {1'b1, 2'd0, 4'd4}) begin
      errors++;
      $display("FAIL tie: got v=%0b id=%0d str=%0d exp v=1 id=0 str=4",
               ep_valid, ep_id, ep_strength);
    end
    window(2'd2, 1);
`ifdef EP_DECAY_EN
    checks++;
    if ({ep_valid, ep_id, ep_strength} !== {1'b1, 2'd0, 4'd3}) begin
      errors++;
      $display("FAIL track_low: got v=%0b id=%0d str=%0d exp v=1 id=0 str=3",
               ep_valid, ep_id, ep_strength);
    end
`else
    checks++;
    if ({ep_valid, ep_id, ep_strength} !== {1'b1, 2'd0, 4'd4}) begin
      errors++;
      $display("FAIL track_low: got v=%0b id=%0d str=%0d exp v=1 id=0 str=4",
               ep_valid, ep_id, ep_strength);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_str [3];
    logic       exp_v   [3];
`ifdef EP_DECAY_EN
    exp_str = '{4'd7, 4'd6, 4'd0};
`else
    exp_str = '{4'd8, 4'd8, 4'd0};
`endif
    exp_v = '{1'b1, 1'b1, 1'b0};
    apply_reset();
    window(2'd2, 2);
    window(2'd2, 2);
    window(2'd2, 2);
    // empty windows followed by a qualifying one: empty count must clear
    tick();
    tick();
    window(2'd2, 2);
    tick();
    tick();
    checks++;
`ifdef EP_DECAY_EN
    if ({ep_valid, ep_id, ep_strength} !== {1'b1, 2'd2, 4'd6}) begin
      errors++;
      $display("FAIL empty_clear: got v=%0b id=%0d str=%0d exp v=1 id=2 str=6",
               ep_valid, ep_id, ep_strength);
    end
`else
    if ({ep_valid, ep_id, ep_strength} !== {1'b1, 2'd2, 4'd10}) begin
      errors++;
      $display("FAIL empty_clear: got v=%0b id=%0d str=%0d exp v=1 id=2 str=10",
               ep_valid, ep_id, ep_strength);
    end
`endif
    apply_reset();
    window(2'd2, 2);
    window(2'd2, 2);
    window(2'd2, 2);
    for (int w = 0; w < 3; w++) begin
      tick();
      checks++;
      if ({ep_valid, ep_strength, ep_update} !== {exp_v[w], exp_str[w], 1'b1}) begin
        errors++;
        $display("FAIL empty_%0d: got v=%0b str=%0d upd=%0b exp v=%0b str=%0d upd=1",
                 w, ep_valid, ep_strength, ep_update, exp_v[w], exp_str[w]);
      end
    end
    checks++;
    if (ep_id !== 2'd0) begin
      errors++;
      $display("FAIL empty_id: got %0d exp 0", ep_id);
    end
  endtask

  task automatic test_coincident_and_reset();
    apply_reset();
    spike(2'd3);
    theta_tick  = 1'b1;
    spike_valid = 1'b1;
    spike_id    = 2'd3;
    step();
    theta_tick  = 1'b0;
    spike_valid = 1'b0;
    checks++;
    if ({ep_valid, ep_update} !== 2'b01) begin
      errors++;
      $display("FAIL coinc_first: got v=%0b upd=%0b exp v=0 upd=1", ep_valid, ep_update);
    end
    window(2'd3, 1);
    checks++;
    if ({ep_valid, ep_id, ep_strength} !== {1'b1, 2'd3, 4'd4}) begin
      errors++;
      $display("FAIL coinc_second: got v=%0b id=%0d str=%0d exp v=1 id=3 str=4",
               ep_valid, ep_id, ep_strength);
    end
    apply_reset();
    spike(2'd1); spike(2'd1); spike(2'd1);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ep_valid, ep_id, ep_strength, ep_update} !== 8'b0) begin
      errors++;
      $display("FAIL midreset: got v=%0b id=%0d str=%0d upd=%0b exp all 0",
               ep_valid, ep_id, ep_strength, ep_update);
    end
    step();
    rst_n = 1'b1;
    step();
    window(2'd1, 1);
    checks++;
    if ({ep_valid, ep_id, ep_strength, ep_update} !== {1'b0, 2'd0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL votes_discarded: got v=%0b id=%0d str=%0d upd=%0b exp v=0 id=0 str=0 upd=1",
               ep_valid, ep_id, ep_strength, ep_update);
    end
  endtask

  initial begin
    test_reset();
    test_create();
    test_reinforce();
    test_replace();
    test_tie_and_low();
    test_back_to_back();
    test_coincident_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
